// File: rtl/rca8_adder_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// The master drives operands; the slave (the adder) returns the registered result.
interface rca8_adder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             out_valid;

  modport master (output a, b, input sum, cout, out_valid);
  modport slave  (input a, b, output sum, cout, out_valid);
endinterface

// File: rtl/rca8_adder.sv
// Unsigned WIDTH-bit ripple-carry adder built from 1-bit full-adder cells,
// with the sum/carry register at the block boundary (1-cycle latency).
module rca8_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

module rca8_adder #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  rca8_adder_if.slave  bus
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             vld_q;

  // No carry-in port: the chain always starts from zero.
  assign c[0] = 1'b0;

  // Plain ripple, one cell per bit; an X on a bit only reaches that bit and above.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    rca8_fa u_fa (
      .a  (bus.a[i]),
      .b  (bus.b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      sum_q  <= s;
      cout_q <= c[WIDTH];
      vld_q  <= 1'b1;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.out_valid = vld_q;
endmodule

// File: tb/tb_rca8_adder.sv
// Scoreboard bench for rca8_adder: expected {cout,sum} queued at drive time,
// popped and compared one cycle later; plus async reset and X-isolation checks.
module tb_rca8_adder;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [8:0] sb[$];

  rca8_adder_if #(.WIDTH(8)) bus ();

  rca8_adder #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a falling edge: compare the result captured at the preceding rising edge.
  task automatic check_out();
    logic [8:0] e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("sum",  {8'h0, bus.sum},         {8'h0, e[7:0]});
      chk("cout", {15'h0, bus.cout},       {15'h0, e[8]});
      chk("vld",  {15'h0, bus.out_valid},  16'h1);
    end
  endtask

  task automatic step(input logic [7:0] x, input logic [7:0] y);
    check_out();
    bus.a = x;
    bus.b = y;
    sb.push_back({1'b0, x} + {1'b0, y});
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] xa;
    rst   = 1'b1;
    bus.a = 8'h00;
    bus.b = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_sum",  {8'h0, bus.sum},        16'h0);
    chk("rst_cout", {15'h0, bus.cout},      16'h0);
    chk("rst_vld",  {15'h0, bus.out_valid}, 16'h0);

    rst = 1'b0;
    step(8'h00, 8'h00);
    step(8'hFF, 8'h01);
    step(8'hFF, 8'hFF);
    step(8'hAA, 8'h55);
    step(8'h55, 8'hAA);
    step(8'h80, 8'h80);
    step(8'h01, 8'hFF);
    step(8'h7F, 8'h01);
    step(8'hFF, 8'hFF);
    check_out();

    // Async reset between edges while sum holds 0xFE.
    chk("pre_rst_sum", {8'h0, bus.sum}, 16'h00FE);
    bus.a = 8'h12;
    bus.b = 8'h34;
    #2 rst = 1'b1;
    #1;
    chk("arst_sum",  {8'h0, bus.sum},        16'h0);
    chk("arst_cout", {15'h0, bus.cout},      16'h0);
    chk("arst_vld",  {15'h0, bus.out_valid}, 16'h0);
    // Held through a rising edge, with X on the operand MSB.
    xa    = 8'h01;
    xa[7] = 1'bx;
    bus.a = xa;
    bus.b = 8'h05;
    @(negedge clk);
    chk("hold_sum", {8'h0, bus.sum},        16'h0);
    chk("hold_vld", {15'h0, bus.out_valid}, 16'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("xlo_sum", {9'h0, bus.sum[6:0]},   16'h0006);
    chk("xlo_vld", {15'h0, bus.out_valid}, 16'h1);

    // Release mid-stream: the first edge loads the current operands.
    bus.a = 8'h12;
    bus.b = 8'h34;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_sum",  {8'h0, bus.sum},        16'h0046);
    chk("rel_cout", {15'h0, bus.cout},      16'h0);
    chk("rel_vld",  {15'h0, bus.out_valid}, 16'h1);

    // Exhaustive sweep, one pair per cycle.
    for (int i = 0; i < 65536; i++) begin
      step(i[15:8], i[7:0]);
    end
    check_out();
    chk("sb_empty", 16'(sb.size()), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
